// File: rtl/mul_stream_ctrl.sv
// Stream controller for the pipelined sign-magnitude Q16 multiplier.
// Issues operand pairs, tags in-flight products and accumulates a dot product.
module mul_stream_ctrl #(
  parameter int MUL_WIDTH  = 17,
  parameter int PROD_WIDTH = 32,
  parameter int MUL_LAT    = 10,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vec_start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MUL_WIDTH-1:0]  in_a,
  input  logic [MUL_WIDTH-1:0]  in_b,
  output logic                  mul_start,
  output logic [MUL_WIDTH-1:0]  mul_a,
  output logic [MUL_WIDTH-1:0]  mul_b,
  input  logic [PROD_WIDTH-1:0] mul_data,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic                 tag_q;
  logic [MUL_LAT-1:0]   pipe_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic                 hs;
  logic                 active;
  logic                 acc_en;
  logic                 tags_clear;

  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign acc_en   = active && pipe_q[MUL_LAT-1];
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){mul_data[PROD_WIDTH-1]}},
                     mul_data};
  assign acc_nxt  = acc_en ? acc_q + prod_ext : acc_q;

  // Only the output slot may still hold a tag: it is consumed this cycle,
  // so the pipe is empty once this edge has passed.
  assign tags_clear = !tag_q && (pipe_q[MUL_LAT-2:0] == '0);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    hs       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vec_start) begin
          state_d = (vec_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        hs       = in_valid;
        if (in_valid && (cnt_q == len_q - LEN_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tags_clear) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      tag_q     <= 1'b0;
      pipe_q    <= '0;
      acc_q     <= '0;
      acc_out   <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;

      if ((state_q == IDLE) && vec_start) begin
        len_q     <= vec_len;
        cnt_q     <= '0;
        acc_q     <= '0;
        busy      <= 1'b1;
        mul_start <= (vec_len != '0);
      end

      // Bubbles feed zero operands so the multiplier keeps advancing.
      if (active) begin
        mul_a  <= hs ? in_a : '0;
        mul_b  <= hs ? in_b : '0;
        tag_q  <= hs;
        pipe_q <= {pipe_q[MUL_LAT-2:0], tag_q};
        acc_q  <= acc_nxt;
        if (hs) begin
          cnt_q <= cnt_q + LEN_WIDTH'(1);
        end
      end

      if ((state_d == DONE) && (state_q != DONE)) begin
        done      <= 1'b1;
        mul_start <= 1'b0;
        acc_out   <= active ? acc_nxt : '0;
      end

      if (state_q == DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// Bench for mul_stream_ctrl: behavioural multiplier plus a
// sum-of-products reference model, with randomized operand streams.
module tb_mul_stream_ctrl;

  localparam int MW = 17;
  localparam int PW = 32;
  localparam int ML = 10;
  localparam int AW = 40;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vec_start;
  logic [LW-1:0] vec_len;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_a;
  logic [MW-1:0] in_b;
  logic          mul_start;
  logic [MW-1:0] mul_a;
  logic [MW-1:0] mul_b;
  logic [PW-1:0] mul_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] acc_out;

  mul_stream_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_start (vec_start),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_data  (mul_data),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  function automatic longint prod(input logic [MW-1:0] a,
                                  input logic [MW-1:0] b);
    longint m;
    m = longint'({48'd0, a[15:0]}) * longint'({48'd0, b[15:0]});
    m = m >>> 16;
    return (a[16] ^ b[16]) ? -m : m;
  endfunction

  function automatic logic [MW-1:0] rnd_op();
    return {1'($urandom_range(1)), 16'($urandom_range(65535))};
  endfunction

  // Multiplier: ML stages, advancing only while mul_start is high.
  logic [PW-1:0] mstage [ML];
  assign mul_data = mstage[ML-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ML; i++) mstage[i] <= '0;
    end else if (mul_start) begin
      mstage[0] <= PW'(prod(mul_a, mul_b));
      for (int i = 1; i < ML; i++) mstage[i] <= mstage[i-1];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int            cyc = 0;
  int            done_cnt;
  int            done_cyc;
  logic [AW-1:0] done_acc;
  int            ms_viol;
  int            op_viol;
  int            ms_high;
  bit            issuing;
  bit            hs_q;
  logic [MW-1:0] a_q;
  logic [MW-1:0] b_q;

  logic [MW-1:0] qa [$];
  logic [MW-1:0] qb [$];
  bit            vq [$];

  // One cycle: observe at the falling edge, judging what the last
  // decided handshake should have produced.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (busy) begin
      if (hs_q ? (mul_a !== a_q || mul_b !== b_q)
               : (mul_a !== '0 || mul_b !== '0)) op_viol++;
      if (mul_start) ms_high++;
    end
    if (issuing && !done && !mul_start) ms_viol++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_acc = acc_out;
      issuing  = 1'b0;
    end
    hs_q = 1'b0;
  endtask

  task automatic run_vec(input int len, input int bub, input bit inject,
                         input bit abort, input string nm);
    longint        exp = 0;
    int            n = 0;
    int            g = 0;
    int            last_cyc = 0;
    int            st_cyc;
    int            d;
    int            lo;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    bit            v;
    logic [AW-1:0] e40;
    done_cnt = 0;
    ms_viol  = 0;
    op_viol  = 0;
    ms_high  = 0;
    issuing  = 1'b0;
    vec_start = 1'b1;
    vec_len   = LW'(len);
    st_cyc    = cyc;
    tick();
    vec_start = 1'b0;
    while (n < len && g < 4000) begin
      v = (vq.size() > 0) ? vq.pop_front() : ($urandom_range(99) >= bub);
      a = (qa.size() > 0) ? qa[0] : rnd_op();
      b = (qb.size() > 0) ? qb[0] : rnd_op();
      in_valid = v;
      in_a     = a;
      in_b     = b;
      if (inject && n == 1) begin
        vec_start = 1'b1;
        vec_len   = 8'd200;
      end
      if (v && in_ready) begin
        hs_q = 1'b1;
        a_q  = a;
        b_q  = b;
        exp += prod(a, b);
        n++;
        last_cyc = cyc;
        issuing  = 1'b1;
        if (qa.size() > 0) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
      end
      tick();
      in_valid  = 1'b0;
      vec_start = 1'b0;
      g++;
    end
    vq.delete();
    chk({nm, "/issued"}, 64'(n), 64'(len));
    if (abort) begin
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk({nm, "/rst_ctl"}, {in_ready, mul_start, busy, done}, 4'b0);
      chk({nm, "/rst_ops"}, {mul_a, mul_b}, '0);
      chk({nm, "/rst_acc"}, acc_out, '0);
      issuing = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (15) tick();
      chk({nm, "/no_done"}, 64'(done_cnt), 64'(0));
      return;
    end
    g = 0;
    while (done_cnt == 0 && g < 40) begin
      tick();
      g++;
    end
    chk({nm, "/done_seen"}, 64'(done_cnt), 64'(1));
    e40 = exp[AW-1:0];
    chk({nm, "/acc"}, done_acc, e40);
    d  = done_cyc - ((len == 0) ? st_cyc : last_cyc);
    lo = (len == 0) ? 1 : ML + 1;
    chk($sformatf("%s/latency_%0d", nm, d), 64'(d >= lo && d <= lo + 1), 64'(1));
    chk({nm, "/mul_start_held"}, 64'(ms_viol), 64'(0));
    chk({nm, "/operands"}, 64'(op_viol), 64'(0));
    if (len == 0) chk({nm, "/no_mul_start"}, 64'(ms_high), 64'(0));
    // A start request landing on the done cycle must be dropped.
    vec_start = 1'b1;
    vec_len   = 8'd3;
    tick();
    vec_start = 1'b0;
    chk({nm, "/busy_after"}, 64'(busy), 64'(0));
    repeat (3) tick();
    chk({nm, "/no_restart"}, {busy, 32'(done_cnt)}, {1'b0, 32'd1});
  endtask

  initial begin
    rst_n     = 1'b0;
    vec_start = 1'b0;
    vec_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    hs_q      = 1'b0;
    a_q       = '0;
    b_q       = '0;
    issuing   = 1'b0;
    done_cnt  = 0;
    repeat (2) @(negedge clk);
    chk("reset/in_ready", 64'(in_ready), 64'(0));
    chk("reset/mul_start", 64'(mul_start), 64'(0));
    chk("reset/mul_ops", {mul_a, mul_b}, '0);
    chk("reset/busy_done", {busy, done}, 2'b0);
    chk("reset/acc_out", acc_out, '0);
    rst_n = 1'b1;

    repeat (3) begin
      qa.push_back(17'h08000);
      qb.push_back(17'h08000);
    end
    run_vec(3, 0, 1'b0, 1'b0, "t1_b2b");

    qa.push_back(17'h18000); qb.push_back(17'h08000);
    qa.push_back(17'h08000); qb.push_back(17'h08000);
    run_vec(2, 0, 1'b0, 1'b0, "t2_sign");

    vq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_vec(4, 0, 1'b0, 1'b0, "t3_bubble");

    run_vec(0, 0, 1'b0, 1'b0, "t4_len0");

    run_vec(5, 20, 1'b0, 1'b1, "t5_abort");
    qa.push_back(17'h08000);
    qb.push_back(17'h08000);
    run_vec(1, 0, 1'b0, 1'b0, "t5_after");

    run_vec(6, 25, 1'b1, 1'b0, "t6_inject");

    repeat (255) begin
      qa.push_back(17'h1FFFF);
      qb.push_back(17'h0FFFF);
    end
    run_vec(255, 0, 1'b0, 1'b0, "t7_maxlen");

    for (int r = 0; r < 8; r++) begin
      run_vec(int'($urandom_range(1, 20)), 30, 1'b0, 1'b0,
              $sformatf("t8_rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
